fifo_packetizer: RTL and testbench

- Downstream consumer of the 128x32 FIFO. Pops words through the FIFO's show-ahead read port (head word visible while `empty`=0, popped on the `read` edge).
- Frames the words into fixed-length packets: header word, PKT_LEN payload words, XOR-checksum trailer.
- Emits packets on a valid/ready stream toward the link/output stage.
- The FIFO's `status` occupancy count gates packet start, so a packet body never stalls on an empty FIFO in normal operation.

---
 rtl/fifo_packetizer.sv | 174 +++++++++++++++++
 tb/tb_fifo_packetizer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_packetizer.sv
// Frames words popped from a show-ahead FIFO into fixed-length packets:
// header, PKT_LEN payload words, XOR checksum trailer, on a valid/ready stream.
module fifo_packetizer #(
    parameter int          PKT_LEN = 4,
    parameter logic [7:0]  HDR_TAG = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fifo_data,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_status,
    output logic        fifo_read,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic        pkt_done,
    output logic [7:0]  seq
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAILER = 2'd2
    } state_t;

    localparam logic [7:0]  LEN_B    = 8'(PKT_LEN);
    localparam logic [7:0]  LAST_CNT = 8'(PKT_LEN - 1);
    localparam logic [15:0] HDR_LEN  = 16'(PKT_LEN);

    function automatic logic [31:0] csum_next(input logic [31:0] csum, input logic [31:0] word);
        csum_next = csum ^ word;
    endfunction

    function automatic logic [31:0] make_header(input logic [7:0] seq_num);
        make_header = {HDR_TAG, seq_num, HDR_LEN};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        done_q, done_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] csum_q, csum_d;
    logic        load_en_s;
    logic        accept_s;
    logic        pop_s;

    assign load_en_s = ~valid_q | out_ready;
    assign accept_s  = valid_q & out_ready;

    // Next-state, output-register and pop decode
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        pop_s   = 1'b0;

        // Trailer acceptance can coincide with the next header load, so the
        // header uses the already-advanced sequence number.
        if (accept_s & eop_q) begin
            seq_d  = seq_q + 8'd1;
            done_d = 1'b1;
        end else begin
            seq_d  = seq_q;
            done_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (load_en_s) begin
                    if (fifo_status >= LEN_B) begin
                        data_d  = make_header(seq_d);
                        valid_d = 1'b1;
                        sop_d   = 1'b1;
                        eop_d   = 1'b0;
                        csum_d  = 32'd0;
                        cnt_d   = 8'd0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (load_en_s) begin
                    if (!fifo_empty) begin
                        pop_s   = 1'b1;
                        data_d  = fifo_data;
                        valid_d = 1'b1;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        csum_d  = csum_next(csum_q, fifo_data);
                        cnt_d   = cnt_q + 8'd1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = ST_TRAILER;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end else begin
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_TRAILER: begin
                if (load_en_s) begin
                    data_d  = csum_q;
                    valid_d = 1'b1;
                    sop_d   = 1'b0;
                    eop_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TRAILER;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            done_q  <= 1'b0;
            seq_q   <= 8'd0;
            cnt_q   <= 8'd0;
            csum_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            done_q  <= done_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
        end
    end

    assign fifo_read = pop_s & ~reset;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign pkt_done  = done_q;
    assign seq       = seq_q;

endmodule

// File: tb/tb_fifo_packetizer.sv
// Bench for fifo_packetizer: queue-based FIFO model, packet-level scoreboard
// checked every cycle, and directed scenarios with literal expectations.
module tb_fifo_packetizer;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fifo_data = 32'd0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_status = 8'd0;
    logic        fifo_read;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sop;
    logic        out_eop;
    logic        pkt_done;
    logic [7:0]  seq;

    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'd0;

    logic [31:0] fq[$];
    logic [31:0] exp_words[$];
    logic [31:0] acc_log[$];

    int n_cmp = 0;
    int n_bad = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int reset_base = 1000000;

    fifo_packetizer #(.PKT_LEN(P), .HDR_TAG(8'hA5)) dut (
        .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_status(fifo_status), .fifo_read(fifo_read), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
        .out_eop(out_eop), .pkt_done(pkt_done), .seq(seq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Show-ahead FIFO model: pop on read, write on wr_en, flags update after the edge
    always @(posedge clk) begin
        if (fifo_read && fq.size() > 0) void'(fq.pop_front());
        if (wr_en) fq.push_back(wr_data);
        fifo_data   <= (fq.size() > 0) ? fq[0] : 32'd0;
        fifo_empty  <= (fq.size() == 0);
        fifo_status <= 8'(fq.size());
    end

    // Packet-level reference: header, P words, XOR trailer, seq advancing per packet
    int          m_pos = 0;
    logic [7:0]  m_seq = 8'd0;
    logic [31:0] m_csum = 32'd0;
    logic        done_pend = 1'b0;
    logic        resync_pend = 1'b0;

    always @(negedge clk) begin
        logic [31:0] e_data;
        logic        e_sop, e_eop;
        if (reset) begin
            chk("read_in_reset", 32'(fifo_read), 32'd0);
            resync_pend = 1'b1;
            done_pend   = 1'b0;
        end else begin
            if (resync_pend) begin
                exp_words   = fq;
                m_pos       = 0;
                m_seq       = 8'd0;
                m_csum      = 32'd0;
                reset_base  = acc_log.size();
                resync_pend = 1'b0;
            end
            chk("pkt_done", 32'(pkt_done), 32'(done_pend));
            chk("seq", 32'(seq), 32'(m_seq));
            chk("sop_eop_excl", 32'(out_sop & out_eop), 32'd0);
            if (pkt_done) done_cnt++;
            if (fifo_read) begin
                pop_cnt++;
                chk("read_guard", 32'(fifo_empty | (out_valid & ~out_ready)), 32'd0);
            end
            done_pend = 1'b0;
            if (out_valid && out_ready) begin
                e_sop = (m_pos == 0);
                e_eop = (m_pos == P + 1);
                if (m_pos == 0) begin
                    e_data = {8'hA5, m_seq, 16'(P)};
                    m_csum = 32'd0;
                end else if (m_pos <= P) begin
                    if (exp_words.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL model_underflow: payload beat with no queued word at %0t", $time);
                        e_data = 32'd0;
                    end else begin
                        e_data = exp_words.pop_front();
                    end
                    m_csum = m_csum ^ e_data;
                end else begin
                    e_data = m_csum;
                end
                chk("beat_data", out_data, e_data);
                chk("beat_sop", 32'(out_sop), 32'(e_sop));
                chk("beat_eop", 32'(out_eop), 32'(e_eop));
                acc_log.push_back(out_data);
                if (e_eop) begin
                    done_pend = 1'b1;
                    m_seq     = m_seq + 8'd1;
                    m_pos     = 0;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        exp_words.push_back(w);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int c;
        c = 0;
        while (done_cnt < target && c < 300) begin
            tick();
            c++;
        end
        if (done_cnt < target) chk("wait_done_timeout", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        logic [31:0] wv;
        int          c;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_sop", 32'(out_sop), 32'd0);
        chk("rst_eop", 32'(out_eop), 32'd0);
        chk("rst_seq", 32'(seq), 32'd0);

        // Start gating, then basic packet
        push(32'h11111111);
        push(32'h22222222);
        push(32'h33333333);
        repeat (5) tick();
        chk("gate_valid", 32'(out_valid), 32'd0);
        chk("gate_pops", 32'(pop_cnt), 32'd0);
        push(32'h44444444);
        chk("hdr_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("hdr_valid", 32'(out_valid), 32'd1);
        chk("hdr_sop", 32'(out_sop), 32'd1);
        chk("hdr_data", out_data, 32'hA5000004);
        wait_done(1);
        tick();
        chk("p1_log0", acc_log[0], 32'hA5000004);
        chk("p1_log1", acc_log[1], 32'h11111111);
        chk("p1_trailer", acc_log[5], 32'h44444444);
        chk("p1_pops", 32'(pop_cnt), 32'd4);
        chk("p1_done_cnt", 32'(done_cnt), 32'd1);
        chk("p1_seq", 32'(seq), 32'd1);

        // Backpressure during payload beat 2
        push(32'h11111111);
        push(32'h22222222);
        push(32'h33333333);
        push(32'h44444444);
        c = 0;
        while (!(out_valid && out_data == 32'h22222222) && c < 50) begin
            tick();
            c++;
        end
        chk("bp_reach_beat2", out_data, 32'h22222222);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", out_data, 32'h22222222);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        chk("bp_no_pop", 32'(pop_cnt), 32'd6);
        out_ready = 1'b1;
        wait_done(2);
        tick();
        chk("p2_hdr", acc_log[6], 32'hA5010004);
        chk("p2_trailer", acc_log[11], 32'h44444444);

        // Back-to-back: preload 8 words behind a stalled header, then release
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            wv = {4{8'(k)}};
            push(wv);
        end
        for (int i = 0; i < 12; i++) begin
            chk("b2b_no_bubble", 32'(out_valid), 32'd1);
            out_ready = 1'b1;
            tick();
        end
        chk("b2b_end_idle", 32'(out_valid), 32'd0);
        chk("b2b_hdr1", acc_log[12], 32'hA5020004);
        chk("b2b_hdr2", acc_log[18], 32'hA5030004);
        chk("b2b_trailer2", acc_log[23], 32'h0C0C0C0C);

        // Mid-packet reset after payload beat 2
        push(32'hDEAD0001);
        push(32'hDEAD0002);
        push(32'hDEAD0003);
        push(32'hDEAD0004);
        c = 0;
        while (!(out_valid && out_data == 32'hDEAD0002) && c < 50) begin
            tick();
            c++;
        end
        chk("rst_mid_reach", out_data, 32'hDEAD0002);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_seq", 32'(seq), 32'd0);
        chk("rst_mid_eop", 32'(out_eop), 32'd0);
        tick();

        // Seq wrap: 257 packets after the reset
        wv = 32'h00010000;
        c = 0;
        while (acc_log.size() < reset_base + 257 * (P + 2) && c < 6000) begin
            if (fq.size() < 100) begin
                push(wv);
                wv = wv + 32'd1;
            end else begin
                tick();
            end
            c++;
        end
        if (acc_log.size() < reset_base + 257 * (P + 2)) begin
            chk("wrap_timeout", 32'(acc_log.size()), 32'(reset_base + 257 * (P + 2)));
        end else begin
            chk("post_rst_hdr", acc_log[reset_base], 32'hA5000004);
            chk("post_rst_pay", acc_log[reset_base + 1], 32'hDEAD0003);
            chk("wrap_hdr255", acc_log[reset_base + 255 * (P + 2)], 32'hA5FF0004);
            chk("wrap_hdr256", acc_log[reset_base + 256 * (P + 2)], 32'hA5000004);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
